timer_rr_scheduler: RTL

Round-robin scheduler that shares one cold-boot/periodic timing resource among N_REQ requesters. After enable it runs a single cold-boot warm-up. It then grants the timed slot to one requester at a time. During each slot it drives that requester's output high for the up period, within a full cycle frame. It sits above the timer datapath and hands out timed output windows to downstream channels.

---
 rtl/timer_rr_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/timer_rr_scheduler.sv
// Round-robin owner of one boot/periodic timer; hands out timed slots.
// One cold-boot warm-up, then FULL_CYCLE-long slots with an up window.
module timer_rr_scheduler #(
   parameter int N_REQ            = 4,
   parameter int COLD_BOOT_CYCLE  = 20,
   parameter int FULL_CYCLE       = 23,
   parameter int OUTPUT_UP_PERIOD = 16,
   parameter int CNT_W            = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] o,
   output logic [N_REQ-1:0] done,
   output logic             booted,
   output logic             busy
);

   localparam int PTR_W = $clog2(N_REQ);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BOOT = 2'd1;
   localparam logic [1:0] ARB  = 2'd2;
   localparam logic [1:0] SLOT = 2'd3;

   localparam logic [CNT_W-1:0] BOOT_LAST =
      CNT_W'(COLD_BOOT_CYCLE - 1);
   localparam logic [CNT_W-1:0] FULL_LAST =
      CNT_W'(FULL_CYCLE - 1);
   localparam logic [CNT_W-1:0] UP_C =
      CNT_W'(OUTPUT_UP_PERIOD);
   localparam bit UP_NZ  = (OUTPUT_UP_PERIOD > 0);
   localparam bit ONE_CY = (FULL_CYCLE == 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             booted_q, booted_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] o_q, o_d;
   logic [N_REQ-1:0] done_q, done_d;

   logic             found;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] win_nxt;
   logic [N_REQ-1:0] win_oh;

   assign cnt_inc = cnt_q + 1'b1;

   // Pick the first requester at or above the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N_REQ; i++) begin : search
         logic [PTR_W-1:0] idx;
         idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_nxt = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
   end

   // Next-state and next-output computation for the scheduler FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      booted_d = booted_q;
      grant_d  = grant_q;
      o_d      = o_q;
      done_d   = '0;
      unique case (state_q)
         IDLE: begin
            cnt_d   = '0;
            grant_d = '0;
            o_d     = '0;
            if (en) state_d = booted_q ? ARB : BOOT;
         end
         BOOT: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == BOOT_LAST) begin
               state_d  = ARB;
               booted_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ARB: begin
            grant_d = '0;
            o_d     = '0;
            if (!en) begin
               state_d = IDLE;
            end else if (found) begin
               state_d = SLOT;
               grant_d = win_oh;
               o_d     = UP_NZ ? win_oh : '0;
               done_d  = ONE_CY ? win_oh : '0;
               cnt_d   = '0;
               ptr_d   = win_nxt;
            end
         end
         SLOT: begin
            if (!en || cnt_q == FULL_LAST) begin
               state_d = en ? ARB : IDLE;
               grant_d = '0;
               o_d     = '0;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_inc;
               o_d    = (cnt_inc < UP_C) ? grant_q : '0;
               done_d = (cnt_inc == FULL_LAST) ? grant_q : '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
            o_d     = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ptr_q    <= '0;
         booted_q <= 1'b0;
         busy_q   <= 1'b0;
         grant_q  <= '0;
         o_q      <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         booted_q <= booted_d;
         busy_q   <= busy_d;
         grant_q  <= grant_d;
         o_q      <= o_d;
         done_q   <= done_d;
      end
   end

   assign grant  = grant_q;
   assign o      = o_q;
   assign done   = done_q;
   assign booted = booted_q;
   assign busy   = busy_q;

endmodule
